dcache_write_buffer: RTL and testbench

Parametrised, coalescing store write buffer between the store commit path and the dcache banks. Accepts committed word stores, merges stores to the same cache block into one entry, and drains whole-block partial writes in FIFO order with a per-bank target. Provides a same-cycle store-to-load forwarding lookup. Bank count, depth and block size are parameters, generalising the fixed two-bank dcache organisation.

---
 rtl/dcache_write_buffer.sv | 194 +++++++++++++++++++
 tb/tb_dcache_write_buffer.sv | 319 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_write_buffer.sv
// dcache_write_buffer
// Coalescing store write buffer between the store commit path and the dcache
// banks. Committed word stores are merged into per-block entries, and whole
// blocks drain in FIFO order. A combinational lookup forwards buffered store
// bytes to loads.

module dcache_write_buffer #(
    parameter int WB_DEPTH   = 4,
    parameter int PA_WIDTH   = 34,
    parameter int BLOCK_SIZE = 32,
    parameter int NUM_BANKS  = 2,
    localparam int BOW        = $clog2(BLOCK_SIZE),
    localparam int BANK_W     = (NUM_BANKS > 1) ? $clog2(NUM_BANKS) : 1,
    localparam int BLK_ADDR_W = PA_WIDTH - BOW,
    localparam int CNT_W      = $clog2(WB_DEPTH) + 1
) (
    input  logic                    CLK,
    input  logic                    nRST,
    input  logic                    enq_valid,
    input  logic [PA_WIDTH-1:0]     enq_PA,
    input  logic [31:0]             enq_data,
    input  logic [3:0]              enq_byte_mask,
    output logic                    enq_ready,
    output logic                    drain_valid,
    output logic [BLK_ADDR_W-1:0]   drain_block_addr,
    output logic [BANK_W-1:0]       drain_bank,
    output logic [8*BLOCK_SIZE-1:0] drain_data,
    output logic [BLOCK_SIZE-1:0]   drain_byte_mask,
    input  logic                    drain_ready,
    input  logic [PA_WIDTH-1:0]     lookup_PA,
    output logic                    lookup_hit,
    output logic [31:0]             lookup_data,
    output logic [3:0]              lookup_byte_mask,
    output logic                    empty,
    output logic [CNT_W-1:0]        occupancy
);

    localparam int PTR_W  = $clog2(WB_DEPTH);
    localparam int WIDX_W = BOW - 2;
    localparam int DATA_W = 8 * BLOCK_SIZE;

    // Entry storage and FIFO bookkeeping
    logic                  valid_q [WB_DEPTH];
    logic                  valid_d [WB_DEPTH];
    logic [BLK_ADDR_W-1:0] addr_q  [WB_DEPTH];
    logic [BLK_ADDR_W-1:0] addr_d  [WB_DEPTH];
    logic [DATA_W-1:0]     data_q  [WB_DEPTH];
    logic [DATA_W-1:0]     data_d  [WB_DEPTH];
    logic [BLOCK_SIZE-1:0] mask_q  [WB_DEPTH];
    logic [BLOCK_SIZE-1:0] mask_d  [WB_DEPTH];
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;

    logic [BLK_ADDR_W-1:0] enq_blk;
    logic [WIDX_W-1:0]     enq_widx;
    logic [BLK_ADDR_W-1:0] lookup_blk;
    logic [WIDX_W-1:0]     lookup_widx;
    logic                  match_found;
    logic [PTR_W-1:0]      match_idx;
    logic [DATA_W-1:0]     enq_blk_data;
    logic [DATA_W-1:0]     enq_bit_mask;
    logic [BLOCK_SIZE-1:0] enq_blk_mask;
    logic                  enq_fire;
    logic                  do_merge;
    logic                  do_alloc;
    logic                  do_pop;
    logic [PTR_W-1:0]      lk_idx;
    logic                  unused_pa_bits;

    assign enq_blk        = enq_PA[PA_WIDTH-1:BOW];
    assign enq_widx       = enq_PA[BOW-1:2];
    assign lookup_blk     = lookup_PA[PA_WIDTH-1:BOW];
    assign lookup_widx    = lookup_PA[BOW-1:2];
    assign unused_pa_bits = ^{enq_PA[1:0], lookup_PA[1:0]};

    // Find the non-head entry already holding the store's block; the head is
    // excluded because it is being presented to the dcache and must not change
    always_comb begin
        match_found = 1'b0;
        match_idx   = '0;
        for (int i = 0; i < WB_DEPTH; i++) begin
            if (valid_q[i] && (PTR_W'(i) != head_q) && (addr_q[i] == enq_blk)) begin
                match_found = 1'b1;
                match_idx   = PTR_W'(i);
            end
        end
    end

    // Spread the store word into block-sized data and byte-enable vectors
    always_comb begin
        enq_blk_data = '0;
        enq_bit_mask = '0;
        enq_blk_mask = '0;
        for (int b = 0; b < 4; b++) begin
            if (enq_byte_mask[b]) begin
                enq_blk_mask[{enq_widx, 2'(b)}]        = 1'b1;
                enq_blk_data[{enq_widx, 2'(b), 3'b000} +: 8] = enq_data[b*8 +: 8];
                enq_bit_mask[{enq_widx, 2'(b), 3'b000} +: 8] = 8'hFF;
            end
        end
    end

    assign enq_ready = match_found || (count_q < CNT_W'(WB_DEPTH));
    assign enq_fire  = enq_valid && enq_ready && (enq_byte_mask != 4'b0000);
    assign do_merge  = enq_fire && match_found;
    assign do_alloc  = enq_fire && !match_found;
    assign do_pop    = valid_q[head_q] && drain_ready;

    // Next-state: pop clears the head, then merge into the matching entry or
    // allocate a fresh entry at the tail; merge never targets the head
    always_comb begin
        valid_d = valid_q;
        addr_d  = addr_q;
        data_d  = data_q;
        mask_d  = mask_q;
        head_d  = head_q + PTR_W'(do_pop);
        tail_d  = tail_q + PTR_W'(do_alloc);
        count_d = count_q + CNT_W'(do_alloc) - CNT_W'(do_pop);
        if (do_pop) begin
            valid_d[head_q] = 1'b0;
            addr_d[head_q]  = '0;
            data_d[head_q]  = '0;
            mask_d[head_q]  = '0;
        end
        if (do_merge) begin
            data_d[match_idx] = (data_q[match_idx] & ~enq_bit_mask) | enq_blk_data;
            mask_d[match_idx] = mask_q[match_idx] | enq_blk_mask;
        end
        if (do_alloc) begin
            valid_d[tail_q] = 1'b1;
            addr_d[tail_q]  = enq_blk;
            data_d[tail_q]  = enq_blk_data;
            mask_d[tail_q]  = enq_blk_mask;
        end
    end

    // State registers; reset discards every entry
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < WB_DEPTH; i++) begin
                valid_q[i] <= 1'b0;
                addr_q[i]  <= '0;
                data_q[i]  <= '0;
                mask_q[i]  <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            mask_q  <= mask_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Forwarding: walk entries oldest to youngest so the youngest byte wins
    always_comb begin
        lookup_data      = '0;
        lookup_byte_mask = '0;
        lk_idx           = '0;
        for (int k = 0; k < WB_DEPTH; k++) begin
            lk_idx = head_q + PTR_W'(k);
            if (valid_q[lk_idx] && (addr_q[lk_idx] == lookup_blk)) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask_q[lk_idx][{lookup_widx, 2'(b)}]) begin
                        lookup_byte_mask[b]    = 1'b1;
                        lookup_data[b*8 +: 8]  = data_q[lk_idx][{lookup_widx, 2'(b), 3'b000} +: 8];
                    end
                end
            end
        end
    end

    assign lookup_hit = |lookup_byte_mask;

    assign drain_valid      = valid_q[head_q];
    assign drain_block_addr = addr_q[head_q];
    assign drain_data       = data_q[head_q];
    assign drain_byte_mask  = mask_q[head_q];
    assign empty            = (count_q == '0);
    assign occupancy        = count_q;

    if (NUM_BANKS > 1) begin : g_bank
        assign drain_bank = addr_q[head_q][BANK_W-1:0];
    end else begin : g_single_bank
        assign drain_bank = '0;
    end

endmodule

// File: tb/tb_dcache_write_buffer.sv
// tb_dcache_write_buffer
// Drives a two-bank and a four-bank buffer with identical stimulus and checks
// them against a queue-of-blocks reference model.

module tb_dcache_write_buffer;

    localparam int BLK_W = 29;

    typedef struct {
        logic [BLK_W-1:0] addr;
        logic [255:0]     data;
        logic [31:0]      mask;
    } entry_t;

    logic         CLK;
    logic         nRST;
    logic         enq_valid;
    logic [33:0]  enq_PA;
    logic [31:0]  enq_data;
    logic [3:0]   enq_byte_mask;
    logic         drain_ready;
    logic [33:0]  lookup_PA;

    logic         enq_ready,        enq_ready4;
    logic         drain_valid,      drain_valid4;
    logic [28:0]  drain_block_addr, drain_block_addr4;
    logic [0:0]   drain_bank;
    logic [1:0]   drain_bank4;
    logic [255:0] drain_data,       drain_data4;
    logic [31:0]  drain_byte_mask,  drain_byte_mask4;
    logic         lookup_hit,       lookup_hit4;
    logic [31:0]  lookup_data,      lookup_data4;
    logic [3:0]   lookup_byte_mask, lookup_byte_mask4;
    logic         empty,            empty4;
    logic [2:0]   occupancy,        occupancy4;

    int tests_run;
    int tests_failed;
    entry_t model_q[$];
    logic [BLK_W-1:0] blk_pool [6];

    dcache_write_buffer #(.WB_DEPTH(4), .PA_WIDTH(34), .BLOCK_SIZE(32), .NUM_BANKS(2)) u_dut (
        .CLK(CLK), .nRST(nRST),
        .enq_valid(enq_valid), .enq_PA(enq_PA), .enq_data(enq_data),
        .enq_byte_mask(enq_byte_mask), .enq_ready(enq_ready),
        .drain_valid(drain_valid), .drain_block_addr(drain_block_addr),
        .drain_bank(drain_bank), .drain_data(drain_data),
        .drain_byte_mask(drain_byte_mask), .drain_ready(drain_ready),
        .lookup_PA(lookup_PA), .lookup_hit(lookup_hit), .lookup_data(lookup_data),
        .lookup_byte_mask(lookup_byte_mask), .empty(empty), .occupancy(occupancy)
    );

    dcache_write_buffer #(.WB_DEPTH(4), .PA_WIDTH(34), .BLOCK_SIZE(32), .NUM_BANKS(4)) u_dut4 (
        .CLK(CLK), .nRST(nRST),
        .enq_valid(enq_valid), .enq_PA(enq_PA), .enq_data(enq_data),
        .enq_byte_mask(enq_byte_mask), .enq_ready(enq_ready4),
        .drain_valid(drain_valid4), .drain_block_addr(drain_block_addr4),
        .drain_bank(drain_bank4), .drain_data(drain_data4),
        .drain_byte_mask(drain_byte_mask4), .drain_ready(drain_ready),
        .lookup_PA(lookup_PA), .lookup_hit(lookup_hit4), .lookup_data(lookup_data4),
        .lookup_byte_mask(lookup_byte_mask4), .empty(empty4), .occupancy(occupancy4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [255:0] actual, input logic [255:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    // index of the non-head model entry holding this block, or -1
    function automatic int modelMatch(input logic [BLK_W-1:0] blk);
        int idx;
        idx = -1;
        for (int i = 1; i < model_q.size(); i++)
            if (model_q[i].addr == blk) idx = i;
        return idx;
    endfunction

    task automatic checkModel();
        entry_t h;
        entry_t e;
        logic [31:0] ldata;
        logic [3:0]  lmask;
        int lw;
        int pos;
        logic exp_ready;
        exp_ready = (modelMatch(enq_PA[33:5]) >= 0) || (model_q.size() < 4);
        checkOutput("enq_ready", enq_ready, exp_ready);
        checkOutput("enq_ready4", enq_ready4, exp_ready);
        h = '{addr: '0, data: '0, mask: '0};
        if (model_q.size() > 0) h = model_q[0];
        checkOutput("drain_valid", drain_valid, model_q.size() > 0);
        checkOutput("drain_block_addr", drain_block_addr, h.addr);
        checkOutput("drain_bank", drain_bank, h.addr[0]);
        checkOutput("drain_bank4", drain_bank4, h.addr[1:0]);
        checkOutput("drain_data", drain_data, h.data);
        checkOutput("drain_byte_mask", drain_byte_mask, h.mask);
        checkOutput("empty", empty, model_q.size() == 0);
        checkOutput("occupancy", occupancy, model_q.size());
        checkOutput("occupancy4", occupancy4, model_q.size());
        ldata = '0;
        lmask = '0;
        lw = int'(lookup_PA[4:2]);
        for (int i = 0; i < model_q.size(); i++) begin
            e = model_q[i];
            if (e.addr == lookup_PA[33:5]) begin
                for (int b = 0; b < 4; b++) begin
                    pos = lw * 4 + b;
                    if (e.mask[pos]) begin
                        lmask[b] = 1'b1;
                        ldata[b*8 +: 8] = e.data[pos*8 +: 8];
                    end
                end
            end
        end
        checkOutput("lookup_hit", lookup_hit, |lmask);
        checkOutput("lookup_data", lookup_data, ldata);
        checkOutput("lookup_byte_mask", lookup_byte_mask, lmask);
    endtask

    task automatic modelUpdate();
        entry_t e;
        logic [255:0] ndata;
        logic [31:0]  nmask;
        int m_idx;
        int pos;
        logic fire;
        logic pop;
        m_idx = modelMatch(enq_PA[33:5]);
        fire  = enq_valid && ((m_idx >= 0) || (model_q.size() < 4)) && (enq_byte_mask != 4'b0000);
        pop   = (model_q.size() > 0) && drain_ready;
        ndata = '0;
        nmask = '0;
        for (int b = 0; b < 4; b++) begin
            if (enq_byte_mask[b]) begin
                pos = int'(enq_PA[4:2]) * 4 + b;
                nmask[pos] = 1'b1;
                ndata[pos*8 +: 8] = enq_data[b*8 +: 8];
            end
        end
        if (fire && m_idx >= 0) begin
            e = model_q[m_idx];
            for (int p = 0; p < 32; p++)
                if (nmask[p]) e.data[p*8 +: 8] = ndata[p*8 +: 8];
            e.mask = e.mask | nmask;
            model_q[m_idx] = e;
        end
        if (pop) void'(model_q.pop_front());
        if (fire && m_idx < 0) model_q.push_back('{addr: enq_PA[33:5], data: ndata, mask: nmask});
    endtask

    // drive one cycle's inputs and check outputs at the falling edge
    task automatic applyStimulus(input logic ev, input logic [33:0] pa, input logic [31:0] d,
                                 input logic [3:0] m, input logic dr, input logic [33:0] lpa);
        enq_valid     = ev;
        enq_PA        = pa;
        enq_data      = d;
        enq_byte_mask = m;
        drain_ready   = dr;
        lookup_PA     = lpa;
        @(negedge CLK);
        checkModel();
    endtask

    task automatic clockEdge();
        @(posedge CLK);
        modelUpdate();
        #1;
    endtask

    task automatic runCycle(input logic ev, input logic [33:0] pa, input logic [31:0] d,
                            input logic [3:0] m, input logic dr, input logic [33:0] lpa);
        applyStimulus(ev, pa, d, m, dr, lpa);
        clockEdge();
    endtask

    task automatic flushAll();
        for (int i = 0; i < 8 && model_q.size() > 0; i++)
            runCycle(1'b0, '0, '0, 4'h0, 1'b1, '0);
        checkOutput("flush_occupancy", occupancy, 3'd0);
    endtask

    initial begin
        logic [33:0] pa_r;
        logic [33:0] lpa_r;
        tests_run    = 0;
        tests_failed = 0;
        blk_pool[0] = 29'h0000_0000;
        blk_pool[1] = 29'h0000_0001;
        blk_pool[2] = 29'h0000_0002;
        blk_pool[3] = 29'h0000_0003;
        blk_pool[4] = 29'h1FFF_FFFF;
        blk_pool[5] = 29'h1000_0006;
        nRST          = 1'b0;
        enq_valid     = 1'b0;
        enq_PA        = '0;
        enq_data      = '0;
        enq_byte_mask = '0;
        drain_ready   = 1'b0;
        lookup_PA     = '0;
        #12 nRST = 1'b1;
        @(posedge CLK);
        #1;

        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0, '0);
        checkOutput("rst_drain_valid", drain_valid, 1'b0);
        checkOutput("rst_empty", empty, 1'b1);
        checkOutput("rst_enq_ready", enq_ready, 1'b1);
        clockEdge();

        runCycle(1'b1, 34'h44, 32'hAABBCCDD, 4'hF, 1'b0, 34'h44);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0, 34'h44);
        checkOutput("t1_drain_valid", drain_valid, 1'b1);
        checkOutput("t1_block_addr", drain_block_addr, 29'h2);
        checkOutput("t1_bank", drain_bank, 1'b0);
        checkOutput("t1_mask", drain_byte_mask, 32'h0000_00F0);
        checkOutput("t1_occupancy", occupancy, 3'd1);
        checkOutput("t1_lookup_data", lookup_data, 32'hAABBCCDD);
        checkOutput("t1_lookup_mask", lookup_byte_mask, 4'hF);
        clockEdge();
        flushAll();

        runCycle(1'b1, 34'h40, 32'h01020304, 4'hF, 1'b0, '0);
        runCycle(1'b1, 34'h60, 32'h00001122, 4'h3, 1'b0, '0);
        runCycle(1'b1, 34'h64, 32'h55667788, 4'hF, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0, 34'h60);
        checkOutput("co_occupancy", occupancy, 3'd2);
        checkOutput("co_lookup_data", lookup_data, 32'h0000_1122);
        checkOutput("co_lookup_mask", lookup_byte_mask, 4'h3);
        clockEdge();
        runCycle(1'b1, 34'h40, 32'hDEADBEEF, 4'hF, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0, 34'h40);
        checkOutput("co_head_excluded", occupancy, 3'd3);
        checkOutput("co_youngest", lookup_data, 32'hDEADBEEF);
        clockEdge();

        runCycle(1'b1, 34'h80, 32'h0BADF00D, 4'hF, 1'b0, '0);
        applyStimulus(1'b1, 34'hA0, 32'h1, 4'hF, 1'b0, '0);
        checkOutput("full_stall", enq_ready, 1'b0);
        clockEdge();
        applyStimulus(1'b1, 34'h68, 32'h99, 4'hF, 1'b0, '0);
        checkOutput("full_coalesce", enq_ready, 1'b1);
        clockEdge();
        applyStimulus(1'b1, 34'hA0, 32'h2, 4'hF, 1'b1, '0);
        checkOutput("full_pop_stall", enq_ready, 1'b0);
        clockEdge();
        applyStimulus(1'b1, 34'hA0, 32'h3, 4'hF, 1'b0, '0);
        checkOutput("full_freed", enq_ready, 1'b1);
        checkOutput("full_freed_occ", occupancy, 3'd3);
        clockEdge();
        flushAll();

        runCycle(1'b1, 34'h80, 32'h0000_0011, 4'h1, 1'b0, '0);
        runCycle(1'b1, 34'h80, 32'h0000_3322, 4'h3, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0, 34'h80);
        checkOutput("fwd_data", lookup_data, 32'h0000_3322);
        checkOutput("fwd_mask", lookup_byte_mask, 4'h3);
        clockEdge();

        applyStimulus(1'b1, 34'hC0, 32'hFFFF_FFFF, 4'h0, 1'b0, '0);
        checkOutput("zero_mask_ready", enq_ready, 1'b1);
        clockEdge();
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0, 34'hC0);
        checkOutput("zero_mask_occ", occupancy, 3'd2);
        checkOutput("zero_mask_hit", lookup_hit, 1'b0);
        clockEdge();
        flushAll();

        runCycle(1'b1, 34'h60, 32'h12345678, 4'hF, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0, '0);
        checkOutput("bank4_0x60", drain_bank4, 2'd3);
        checkOutput("bank2_0x60", drain_bank, 1'b1);
        clockEdge();
        flushAll();

        runCycle(1'b1, 34'h100, 32'hCAFE0001, 4'hF, 1'b0, '0);
        runCycle(1'b1, 34'h120, 32'hCAFE0002, 4'hF, 1'b0, '0);
        runCycle(1'b1, 34'h140, 32'hCAFE0003, 4'hF, 1'b0, '0);
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b1, 34'h100);
        #2 nRST = 1'b0;
        #1;
        checkOutput("arst_drain_valid", drain_valid, 1'b0);
        checkOutput("arst_empty", empty, 1'b1);
        checkOutput("arst_occupancy", occupancy, 3'd0);
        checkOutput("arst_enq_ready", enq_ready, 1'b1);
        checkOutput("arst_lookup_hit", lookup_hit, 1'b0);
        checkOutput("arst_lookup_data", lookup_data, 32'h0);
        checkOutput("arst_drain_data", drain_data, 256'h0);
        checkOutput("arst_drain_mask", drain_byte_mask, 32'h0);
        checkOutput("arst_drain_addr", drain_block_addr, 29'h0);
        model_q.delete();
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        @(posedge CLK);
        #1;
        applyStimulus(1'b0, '0, '0, 4'h0, 1'b0, '0);
        checkOutput("arst_release_occ", occupancy, 3'd0);
        clockEdge();

        for (int n = 0; n < 500; n++) begin
            pa_r  = {blk_pool[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            lpa_r = {blk_pool[$urandom_range(0, 5)], 3'($urandom_range(0, 7)), 2'($urandom_range(0, 3))};
            runCycle(($urandom_range(0, 9) < 7), pa_r, $urandom(),
                     ($urandom_range(0, 7) == 0) ? 4'h0 : 4'($urandom_range(0, 15)),
                     ($urandom_range(0, 1) == 1), lpa_r);
        end
        flushAll();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
